// File: rtl/enemy_pkg.sv
// Shared enemy definitions: edge codes reported by the hit detector and
// consumed by the enemy motion FSM, plus the detector state encoding.
package enemy_pkg;

  localparam logic [3:0] EDGE_NONE   = 4'b0000;
  localparam logic [3:0] EDGE_TOP    = 4'b0100;
  localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
  localparam logic [3:0] EDGE_LEFT   = 4'b1000;
  localparam logic [3:0] EDGE_BOTTOM = 4'b0001;

  typedef enum logic [1:0] {
    IDLE_ST,
    SCAN_ST,
    REPORTED_ST
  } det_state_t;

  // Slot of an edge's hit counter; only meaningful for a non-zero edge code.
  function automatic logic [1:0] edge_index(input logic [3:0] code);
    case (code)
      EDGE_TOP:   edge_index = 2'd0;
      EDGE_RIGHT: edge_index = 2'd1;
      EDGE_LEFT:  edge_index = 2'd2;
      default:    edge_index = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/enemy_edge_classifier.sv
// Maps a pixel offset inside the enemy sprite to the sprite edge it lies on,
// using a 4x4 grid of cells; corners and interior give EDGE_NONE.
module enemy_edge_classifier
  import enemy_pkg::*;
#(
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HIGHT_Y = 32
) (
  input  logic signed [11:0] off_x,
  input  logic signed [11:0] off_y,
  output logic        [3:0]  code
);

  localparam int CX_MSB = $clog2(OBJECT_WIDTH_X) - 1;
  localparam int CY_MSB = $clog2(OBJECT_HIGHT_Y) - 1;
  localparam logic signed [11:0] WIDTH_S  = 12'(OBJECT_WIDTH_X);
  localparam logic signed [11:0] HEIGHT_S = 12'(OBJECT_HIGHT_Y);

  logic [1:0] cx;
  logic [1:0] cy;
  logic       in_box;

  // Sizes are powers of two, so the cell index is the top two offset bits.
  assign cx     = off_x[CX_MSB -: 2];
  assign cy     = off_y[CY_MSB -: 2];
  assign in_box = !off_x[11] && !off_y[11] && (off_x < WIDTH_S) && (off_y < HEIGHT_S);

  always_comb begin
    code = EDGE_NONE;
    if (in_box) begin
      if (cy == 2'd0 && (cx == 2'd1 || cx == 2'd2))
        code = EDGE_TOP;
      else if (cy == 2'd3 && (cx == 2'd1 || cx == 2'd2))
        code = EDGE_BOTTOM;
      else if (cx == 2'd0 && (cy == 2'd1 || cy == 2'd2))
        code = EDGE_LEFT;
      else if (cx == 2'd3 && (cy == 2'd1 || cy == 2'd2))
        code = EDGE_RIGHT;
    end
  end

endmodule

// File: rtl/enemy_hit_detector.sv
// Per-pixel enemy/wall overlap detector: classifies overlaps by sprite edge,
// debounces them per frame and issues at most one collision report per frame.
module enemy_hit_detector
  import enemy_pkg::*;
#(
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HIGHT_Y = 32,
  parameter int MIN_HITS       = 4,
  parameter int COUNT_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               game_on,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic               enemy_DR,
  input  logic               wall_DR,
  output logic               collision,
  output logic        [3:0]  HitEdgeCode,
  output logic               valid_enemy_pos
);

  det_state_t state_q, state_d;

  logic signed [11:0] off_x, off_y;
  logic [3:0]         cls_code;
  logic               ov_now;
  logic               ov_q;
  logic [3:0]         code_q;
  logic               any_ov_q;
  logic [COUNT_W-1:0] edge_cnt [4];
  logic [1:0]         edge_idx;
  logic [COUNT_W-1:0] inc_cnt;
  logic               report;
  logic               frame_clear;

  assign off_x  = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y  = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});
  assign ov_now = enemy_DR & wall_DR;

  enemy_edge_classifier #(
    .OBJECT_WIDTH_X(OBJECT_WIDTH_X),
    .OBJECT_HIGHT_Y(OBJECT_HIGHT_Y)
  ) u_classifier (
    .off_x(off_x),
    .off_y(off_y),
    .code (cls_code)
  );

  // Anything that wipes the frame context: reset, game stop, idling, frame start.
  assign frame_clear = reset || !game_on || (state_q == IDLE_ST) || startOfFrame;

  always_comb begin
    edge_idx = edge_index(code_q);
    inc_cnt  = (&edge_cnt[edge_idx]) ? edge_cnt[edge_idx] : edge_cnt[edge_idx] + 1'b1;
    report   = (state_q == SCAN_ST) && (code_q != EDGE_NONE) &&
               (inc_cnt == COUNT_W'(MIN_HITS));
  end

  always_comb begin
    state_d = state_q;
    if (!game_on) begin
      state_d = IDLE_ST;
    end else begin
      case (state_q)
        IDLE_ST:     if (startOfFrame) state_d = SCAN_ST;
        SCAN_ST:     if (startOfFrame) state_d = SCAN_ST;
                     else if (report) state_d = REPORTED_ST;
        REPORTED_ST: if (startOfFrame) state_d = SCAN_ST;
        default:     state_d = IDLE_ST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE_ST;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (frame_clear) begin
      ov_q   <= 1'b0;
      code_q <= EDGE_NONE;
    end else begin
      ov_q   <= ov_now;
      code_q <= ov_now ? cls_code : EDGE_NONE;
    end
  end

  // Frame-start handling takes priority, so a stage 1 hit in that cycle is dropped.
  always_ff @(posedge clk) begin
    collision <= 1'b0;
    if (reset || !game_on || state_q == IDLE_ST) begin
      for (int i = 0; i < 4; i++) edge_cnt[i] <= '0;
      any_ov_q        <= 1'b0;
      HitEdgeCode     <= EDGE_NONE;
      valid_enemy_pos <= 1'b0;
    end else if (startOfFrame) begin
      for (int i = 0; i < 4; i++) edge_cnt[i] <= '0;
      valid_enemy_pos <= !any_ov_q;
      any_ov_q        <= 1'b0;
      HitEdgeCode     <= EDGE_NONE;
    end else begin
      if (ov_q) any_ov_q <= 1'b1;
      if (code_q != EDGE_NONE) edge_cnt[edge_idx] <= inc_cnt;
      if (report) begin
        collision   <= 1'b1;
        HitEdgeCode <= code_q;
      end
    end
  end

endmodule
